// File: rtl/dawson32_pkg.sv
// Shared types and the result function for the Dawson-style 32-bit responder.
package dawson32_pkg;

  localparam int DAWSON_W = 32;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_XOR = 2;

  typedef enum logic [1:0] {
    GET_A,
    GET_B,
    COMPUTE,
    PUT_Z
  } resp_state_t;

  // Unsigned modulo-2^32 arithmetic; no flags are produced.
  function automatic logic [DAWSON_W-1:0] dawson32_op(
    input int                  op,
    input logic [DAWSON_W-1:0] a,
    input logic [DAWSON_W-1:0] b
  );
    logic [DAWSON_W-1:0] res;
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_XOR:  res = a ^ b;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dawson32_int_resp.sv
// Unit-side responder: takes A then B over stb/ack, computes after LATENCY
// cycles and offers the result on output_z with stb/ack.
module dawson32_int_resp
  import dawson32_pkg::*;
#(
  parameter int OP        = OP_ADD,
  parameter int LATENCY   = 1,
  parameter int ACK_DELAY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DAWSON_W-1:0] input_a,
  input  logic                input_a_stb,
  output logic                input_a_ack,
  input  logic [DAWSON_W-1:0] input_b,
  input  logic                input_b_stb,
  output logic                input_b_ack,
  output logic [DAWSON_W-1:0] output_z,
  output logic                output_z_stb,
  input  logic                output_z_ack,
  output logic                busy,
  output logic [15:0]         txn_count
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("dawson32_int_resp: LATENCY must be >= 1");
  end
  if (OP < 0 || OP > 2) begin : g_bad_op
    $error("dawson32_int_resp: OP must be 0, 1 or 2");
  end
  if (ACK_DELAY < 0 || ACK_DELAY > 255) begin : g_bad_delay
    $error("dawson32_int_resp: ACK_DELAY must be in 0..255");
  end

  localparam logic [7:0]  ACK_DELAY_C  = 8'(ACK_DELAY);
  localparam logic [31:0] LAST_LAT_CNT = 32'(LATENCY - 1);

  resp_state_t         state_q;
  logic [7:0]          wait_cnt_q;
  logic [31:0]         lat_cnt_q;
  logic [DAWSON_W-1:0] a_q;
  logic [DAWSON_W-1:0] b_q;
  logic [DAWSON_W-1:0] z_q;
  logic                a_ack_q;
  logic                b_ack_q;
  logic                z_stb_q;
  logic [15:0]         txn_q;

  // Every path into GET_A/GET_B clears wait_cnt so the ack delay restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GET_A;
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      z_q        <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      z_stb_q    <= 1'b0;
      txn_q      <= '0;
    end else begin
      case (state_q)
        GET_A: begin
          if (a_ack_q && input_a_stb) begin
            a_q        <= input_a;
            a_ack_q    <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= GET_B;
          end else if (!a_ack_q) begin
            if (wait_cnt_q == ACK_DELAY_C) a_ack_q <= 1'b1;
            else wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        GET_B: begin
          if (b_ack_q && input_b_stb) begin
            b_q        <= input_b;
            b_ack_q    <= 1'b0;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
            state_q    <= COMPUTE;
          end else if (!b_ack_q) begin
            if (wait_cnt_q == ACK_DELAY_C) b_ack_q <= 1'b1;
            else wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        COMPUTE: begin
          lat_cnt_q <= lat_cnt_q + 32'd1;
          if (lat_cnt_q == LAST_LAT_CNT) begin
            z_q     <= dawson32_op(OP, a_q, b_q);
            z_stb_q <= 1'b1;
            state_q <= PUT_Z;
          end
        end
        PUT_Z: begin
          if (z_stb_q && output_z_ack) begin
            z_stb_q    <= 1'b0;
            txn_q      <= txn_q + 16'd1;
            wait_cnt_q <= '0;
            state_q    <= GET_A;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;
  assign txn_count    = txn_q;
  assign busy         = (state_q != GET_A);

endmodule

// File: tb/tb_dawson32_int_resp.sv
// Directed bench: three lockstep responders (add/sub/xor) plus one slow responder.
module tb_dawson32_int_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic gAStb, gBStb, gZAck;
  logic [31:0] addA, addB, subA, subB, xorA, xorB;

  logic addAAck, addBAck, addZStb, addBusy;
  logic subAAck, subBAck, subZStb, subBusy;
  logic xorAAck, xorBAck, xorZStb, xorBusy;
  logic [31:0] addZ, subZ, xorZ;
  logic [15:0] addTxn, subTxn, xorTxn;

  logic [31:0] slowA, slowB, slowZ;
  logic slowAStb, slowBStb, slowZAck;
  logic slowAAck, slowBAck, slowZStb, slowBusy;
  logic [15:0] slowTxn;

  int assertCount;
  int failCount;

  dawson32_int_resp #(.OP(0), .LATENCY(1), .ACK_DELAY(0)) dutAdd (
    .clk(clk), .rst(rst),
    .input_a(addA), .input_a_stb(gAStb), .input_a_ack(addAAck),
    .input_b(addB), .input_b_stb(gBStb), .input_b_ack(addBAck),
    .output_z(addZ), .output_z_stb(addZStb), .output_z_ack(gZAck),
    .busy(addBusy), .txn_count(addTxn)
  );

  dawson32_int_resp #(.OP(1), .LATENCY(1), .ACK_DELAY(0)) dutSub (
    .clk(clk), .rst(rst),
    .input_a(subA), .input_a_stb(gAStb), .input_a_ack(subAAck),
    .input_b(subB), .input_b_stb(gBStb), .input_b_ack(subBAck),
    .output_z(subZ), .output_z_stb(subZStb), .output_z_ack(gZAck),
    .busy(subBusy), .txn_count(subTxn)
  );

  dawson32_int_resp #(.OP(2), .LATENCY(1), .ACK_DELAY(0)) dutXor (
    .clk(clk), .rst(rst),
    .input_a(xorA), .input_a_stb(gAStb), .input_a_ack(xorAAck),
    .input_b(xorB), .input_b_stb(gBStb), .input_b_ack(xorBAck),
    .output_z(xorZ), .output_z_stb(xorZStb), .output_z_ack(gZAck),
    .busy(xorBusy), .txn_count(xorTxn)
  );

  dawson32_int_resp #(.OP(0), .LATENCY(4), .ACK_DELAY(3)) dutSlow (
    .clk(clk), .rst(rst),
    .input_a(slowA), .input_a_stb(slowAStb), .input_a_ack(slowAAck),
    .input_b(slowB), .input_b_stb(slowBStb), .input_b_ack(slowBAck),
    .output_z(slowZ), .output_z_stb(slowZStb), .output_z_ack(slowZAck),
    .busy(slowBusy), .txn_count(slowTxn)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Expects the lockstep trio to have just entered GET_A.
  task automatic applyStimulus(input logic [15:0] expTxn);
    gAStb = 1'b1;
    gBStb = 1'b1;
    gZAck = 1'b1;
    repeat (4) step();
    checkOutput("stb before result edge", 32'(addZStb), 32'd0);
    step();
    checkOutput("result stb", 32'(addZStb), 32'd1);
    checkOutput("add result", addZ, addA + addB);
    checkOutput("sub result", subZ, subA - subB);
    checkOutput("xor result", xorZ, xorA ^ xorB);
    step();
    checkOutput("stb after transfer", 32'(addZStb), 32'd0);
    checkOutput("txn count", 32'(addTxn), 32'(expTxn));
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    gAStb = 1'b0; gBStb = 1'b0; gZAck = 1'b0;
    addA = '0; addB = '0; subA = '0; subB = '0; xorA = '0; xorB = '0;
    slowA = '0; slowB = '0; slowAStb = 1'b0; slowBStb = 1'b0; slowZAck = 1'b0;
    step();
    step();

    checkOutput("reset a_ack", 32'(addAAck), 32'd0);
    checkOutput("reset b_ack", 32'(addBAck), 32'd0);
    checkOutput("reset z_stb", 32'(addZStb), 32'd0);
    checkOutput("reset z", addZ, 32'd0);
    checkOutput("reset txn", 32'(addTxn), 32'd0);
    checkOutput("reset busy", 32'(addBusy), 32'd0);

    // Minimum round trip, initiator strobing immediately.
    addA = 32'd1; addB = 32'd2;
    subA = 32'd0; subB = 32'd1;
    xorA = 32'hF0F0_F0F0; xorB = 32'hFFFF_0000;
    gAStb = 1'b1; gBStb = 1'b1; gZAck = 1'b1;
    rst = 1'b0;
    step();
    checkOutput("e1 a_ack", 32'(addAAck), 32'd1);
    checkOutput("e1 b_ack", 32'(addBAck), 32'd0);
    checkOutput("e1 busy", 32'(addBusy), 32'd0);
    step();
    checkOutput("e2 a_ack", 32'(addAAck), 32'd0);
    checkOutput("e2 busy", 32'(addBusy), 32'd1);
    step();
    checkOutput("e3 b_ack", 32'(addBAck), 32'd1);
    checkOutput("e3 a_ack", 32'(addAAck), 32'd0);
    step();
    checkOutput("e4 b_ack", 32'(addBAck), 32'd0);
    checkOutput("e4 z_stb", 32'(addZStb), 32'd0);
    step();
    checkOutput("e5 z_stb", 32'(addZStb), 32'd1);
    checkOutput("e5 add z", addZ, 32'd3);
    checkOutput("e5 sub z", subZ, 32'hFFFF_FFFF);
    checkOutput("e5 xor z", xorZ, 32'h0F0F_F0F0);
    step();
    checkOutput("e6 z_stb", 32'(addZStb), 32'd0);
    checkOutput("e6 txn", 32'(addTxn), 32'd1);
    checkOutput("e6 busy", 32'(addBusy), 32'd0);
    checkOutput("e6 z held", addZ, 32'd3);

    // B strobing during GET_A, A late, then result ack withheld.
    gAStb = 1'b0; gBStb = 1'b1; gZAck = 1'b0;
    addA = 32'd5; addB = 32'd6;
    step();
    checkOutput("early b: a_ack", 32'(addAAck), 32'd1);
    checkOutput("early b: b_ack", 32'(addBAck), 32'd0);
    step();
    checkOutput("early b: a_ack held", 32'(addAAck), 32'd1);
    checkOutput("early b: b_ack still", 32'(addBAck), 32'd0);
    gAStb = 1'b1;
    step();
    checkOutput("late a xfer", 32'(addAAck), 32'd0);
    step();
    checkOutput("late b ack", 32'(addBAck), 32'd1);
    step();
    step();
    checkOutput("slow-ack z_stb", 32'(addZStb), 32'd1);
    checkOutput("slow-ack z", addZ, 32'd11);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("held z_stb", 32'(addZStb), 32'd1);
      checkOutput("held z", addZ, 32'd11);
      checkOutput("held no a_ack", 32'(addAAck), 32'd0);
    end
    gZAck = 1'b1;
    step();
    checkOutput("late z xfer stb", 32'(addZStb), 32'd0);
    checkOutput("late z xfer txn", 32'(addTxn), 32'd2);

    // Reset while in COMPUTE.
    addA = 32'd7; addB = 32'd8; gZAck = 1'b0;
    repeat (4) step();
    checkOutput("in compute busy", 32'(addBusy), 32'd1);
    checkOutput("in compute z_stb", 32'(addZStb), 32'd0);
    applyReset();
    checkOutput("rst compute a_ack", 32'(addAAck), 32'd0);
    checkOutput("rst compute b_ack", 32'(addBAck), 32'd0);
    checkOutput("rst compute z_stb", 32'(addZStb), 32'd0);
    checkOutput("rst compute z", addZ, 32'd0);
    checkOutput("rst compute txn", 32'(addTxn), 32'd0);
    checkOutput("rst compute busy", 32'(addBusy), 32'd0);

    // Reset while in PUT_Z.
    repeat (5) step();
    checkOutput("put_z stb", 32'(addZStb), 32'd1);
    checkOutput("put_z z", addZ, 32'd15);
    applyReset();
    checkOutput("rst put_z z_stb", 32'(addZStb), 32'd0);
    checkOutput("rst put_z z", addZ, 32'd0);
    checkOutput("rst put_z txn", 32'(addTxn), 32'd0);
    checkOutput("rst put_z busy", 32'(addBusy), 32'd0);
    applyStimulus(16'd1);

    // Slow responder: ACK_DELAY=3, LATENCY=4, A strobe five cycles late.
    slowA = 32'd100; slowB = 32'd23;
    slowAStb = 1'b0; slowBStb = 1'b1; slowZAck = 1'b0;
    applyReset();
    for (int k = 1; k <= 3; k++) begin
      step();
      checkOutput("slow a_ack low", 32'(slowAAck), 32'd0);
    end
    step();
    checkOutput("slow a_ack rise", 32'(slowAAck), 32'd1);
    step();
    checkOutput("slow a_ack held", 32'(slowAAck), 32'd1);
    slowAStb = 1'b1;
    step();
    checkOutput("slow a xfer", 32'(slowAAck), 32'd0);
    checkOutput("slow busy", 32'(slowBusy), 32'd1);
    slowAStb = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checkOutput("slow b_ack low", 32'(slowBAck), 32'd0);
    end
    step();
    checkOutput("slow b_ack rise", 32'(slowBAck), 32'd1);
    step();
    checkOutput("slow b xfer", 32'(slowBAck), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      checkOutput("slow compute stb", 32'(slowZStb), 32'd0);
    end
    step();
    checkOutput("slow z_stb", 32'(slowZStb), 32'd1);
    checkOutput("slow z", slowZ, 32'd123);
    slowZAck = 1'b1;
    step();
    checkOutput("slow z xfer", 32'(slowZStb), 32'd0);
    checkOutput("slow txn", 32'(slowTxn), 32'd1);
    checkOutput("slow idle", 32'(slowBusy), 32'd0);

    // Back-to-back transactions with wrap-around operands first.
    applyReset();
    for (int i = 0; i < 300; i++) begin
      if (i == 0) begin
        addA = 32'hFFFF_FFFF; addB = 32'd1;
        subA = 32'd0;         subB = 32'hFFFF_FFFF;
        xorA = 32'hFFFF_FFFF; xorB = 32'hFFFF_FFFF;
      end else begin
        addA = $urandom; addB = $urandom;
        subA = $urandom; subB = $urandom;
        xorA = $urandom; xorB = $urandom;
      end
      applyStimulus(16'(i + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
